mem_port_arbiter: RTL and testbench

Shares the single-port data memory between two requesters: port 0 (CPU `read`/`write`/`address`/`mem_out`) and port 1 (program loader / DMA engine).
- Arbitrates between them, latches the winning transaction and drives the memory strobes for MEM_LAT cycles.
- Returns read data with a one-cycle ack pulse.
- Sits between the CPU top level and the memory model; the CPU stalls on ack.

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-port data memory between two requesters.
// Build option: define ARB_FIXED_PRIO_EN to make port 0 win every tie instead of round-robin.
module mem_port_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          gnt_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          gnt_q, gnt_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          win;
`ifndef ARB_FIXED_PRIO_EN
  logic          last_q, last_d;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt_q    <= 1'b0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifndef ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    win      = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
`ifdef ARB_FIXED_PRIO_EN
          win = !m0_req;
`else
          // On a tie, the port that did not own the previous transaction wins.
          win = (m0_req && m1_req) ? !last_q : m1_req;
          last_d = win;
`endif
          we_d    = win ? m1_we    : m0_we;
          addr_d  = win ? m1_addr  : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          gnt_d   = win;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (gnt_q) rdata1_d = mem_rdata;
            else       rdata0_d = mem_rdata;
          end
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and acks decode straight from registered state, so they are glitch-free.
  assign mem_rd    = (state_q == ACCESS) && !we_q;
  assign mem_wr    = (state_q == ACCESS) && we_q;
  assign m0_ack    = (state_q == ACK) && !gnt_q;
  assign m1_ack    = (state_q == ACK) && gnt_q;
  assign busy      = (state_q != IDLE);
  assign gnt_id    = gnt_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// compared against a cycle-arithmetic transaction model.
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  logic        clk;
  logic        rst_b;
  logic        m0_req, m0_we, m0_ack;
  logic [15:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_ack;
  logic [15:0] m1_addr, m1_wdata, m1_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, busy, gnt_id;

  int checks = 0;
  int errors = 0;

  bit          dut_wr  [0:4095];
  logic [15:0] dut_mem [0:4095];
  bit          ref_wr  [0:4095];
  logic [15:0] ref_mem [0:4095];

  mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_b(rst_b),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-up memory contents; address 0x0010 holds 0xBEEF.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a[11:0] == 12'h010) return 16'hBEEF;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_wr[a[11:0]] ? ref_mem[a[11:0]] : init_val(a);
  endfunction

  assign mem_rdata = dut_wr[mem_addr[11:0]] ? dut_mem[mem_addr[11:0]] : init_val(mem_addr);

  always @(posedge clk) begin
    if (mem_wr) begin
      dut_mem[mem_addr[11:0]] <= mem_wdata;
      dut_wr[mem_addr[11:0]]  <= 1'b1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    m0_req = 1'b1; m1_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({m0_ack, m1_ack, mem_rd, mem_wr, busy, gnt_id, m0_rdata, m1_rdata, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ack0=%b ack1=%b rd=%b wr=%b busy=%b gnt=%b rd0=%h rd1=%h addr=%h wdata=%h, all required 0",
               m0_ack, m1_ack, mem_rd, mem_wr, busy, gnt_id, m0_rdata, m1_rdata, mem_addr, mem_wdata);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, mem_rd, mem_wr} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle got busy=%b rd=%b wr=%b required 000", busy, mem_rd, mem_wr);
    end
  endtask

  task automatic test_m0_read();
    int rd_cycles, ack_at, stray;
    rd_cycles = 0; ack_at = -1; stray = 0;
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010; m0_wdata = 16'h0000;
    for (int c = 1; c <= LAT + 8; c++) begin
      @(negedge clk);
      if (mem_rd) begin
        rd_cycles++;
        checks++;
        if (mem_addr !== 16'h0010) begin
          errors++;
          $display("FAIL m0_read_addr got %h required 0010", mem_addr);
        end
      end
      if (mem_wr || m1_ack) stray++;
      if (m0_ack) begin ack_at = c; m0_req = 1'b0; break; end
    end
    checks++;
    if (ack_at != LAT + 1) begin
      errors++; $display("FAIL m0_read_latency got %0d required %0d", ack_at, LAT + 1);
    end
    checks++;
    if (rd_cycles != LAT) begin
      errors++; $display("FAIL m0_read_strobe_cycles got %0d required %0d", rd_cycles, LAT);
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL m0_read_stray got %0d cycles of mem_wr/m1_ack required 0", stray);
    end
    checks++;
    if (m0_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL m0_read_data got %h required beef", m0_rdata);
    end
    checks++;
    if (m1_rdata !== 16'h0000) begin
      errors++; $display("FAIL m0_read_other_rdata got %h required 0000", m1_rdata);
    end
  endtask

  task automatic test_m1_write();
    int wr_cycles, ack_at, stray;
    wr_cycles = 0; ack_at = -1; stray = 0;
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0200; m1_wdata = 16'h1234;
    for (int c = 1; c <= LAT + 8; c++) begin
      @(negedge clk);
      if (mem_wr) begin
        wr_cycles++;
        checks++;
        if ({mem_addr, mem_wdata} !== {16'h0200, 16'h1234}) begin
          errors++;
          $display("FAIL m1_write_bus got addr=%h data=%h required 0200/1234", mem_addr, mem_wdata);
        end
      end
      if (mem_rd || m0_ack) stray++;
      if (m1_ack) begin ack_at = c; m1_req = 1'b0; break; end
    end
    ref_wr[12'h200] = 1'b1;
    ref_mem[12'h200] = 16'h1234;
    checks++;
    if (ack_at != LAT + 1) begin
      errors++; $display("FAIL m1_write_latency got %0d required %0d", ack_at, LAT + 1);
    end
    checks++;
    if (wr_cycles != LAT) begin
      errors++; $display("FAIL m1_write_strobe_cycles got %0d required %0d", wr_cycles, LAT);
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL m1_write_stray got %0d cycles of mem_rd/m0_ack required 0", stray);
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== {16'hBEEF, 16'h0000}) begin
      errors++; $display("FAIL m1_write_rdata got rd0=%h rd1=%h required beef/0000", m0_rdata, m1_rdata);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int ack_c [4];
    bit ack_p [4];
    bit exp_p;
    n = 0;
    do_reset();
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0001;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0002;
    for (int c = 1; c <= 4 * (LAT + 2) + 4; c++) begin
      @(negedge clk);
      checks++;
      if (m0_ack && m1_ack) begin
        errors++; $display("FAIL rr_double_ack at cycle %0d both acks high, required at most one", c);
      end
      if (m0_ack || m1_ack) begin
        ack_p[n] = m1_ack;
        ack_c[n] = c;
        checks++;
        if (gnt_id !== m1_ack) begin
          errors++; $display("FAIL rr_gnt_id got %b required %b", gnt_id, m1_ack);
        end
        n++;
        if (n == 4) begin m0_req = 1'b0; m1_req = 1'b0; break; end
      end
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL rr_ack_count got %0d required 4", n);
    end
    for (int k = 0; k < n; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_p = 1'b0;
`else
      exp_p = (k % 2) == 1;
`endif
      checks++;
      if (ack_p[k] !== exp_p) begin
        errors++; $display("FAIL rr_order txn %0d got port %0d required port %0d", k, ack_p[k], exp_p);
      end
      checks++;
      if ((k == 0 && ack_c[k] != LAT + 1) || (k > 0 && ack_c[k] - ack_c[k-1] != LAT + 2)) begin
        errors++;
        $display("FAIL rr_spacing txn %0d ack at cycle %0d required %0d", k, ack_c[k], (LAT + 1) + k * (LAT + 2));
      end
    end
  endtask

  task automatic test_reset_mid();
    int ack_at, m0_seen;
    ack_at = -1; m0_seen = 0;
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0030;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_rd, busy} !== 2'b11) begin
      errors++; $display("FAIL reset_mid_pre got rd=%b busy=%b required 11", mem_rd, busy);
    end
    rst_b = 1'b0;
    m0_req = 1'b0;
    #1;
    checks++;
    if ({mem_rd, busy, m0_ack, m1_ack} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_abort got rd=%b busy=%b ack0=%b ack1=%b required 0000", mem_rd, busy, m0_ack, m1_ack);
    end
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0040;
    for (int c = 1; c <= LAT + 8; c++) begin
      @(negedge clk);
      if (m0_ack) m0_seen++;
      if (m1_ack) begin
        ack_at = c;
        m1_req = 1'b0;
        checks++;
        if ({gnt_id, m1_rdata} !== {1'b1, ref_rd(16'h0040)}) begin
          errors++;
          $display("FAIL reset_mid_m1 got gnt=%b rd1=%h required 1/%h", gnt_id, m1_rdata, ref_rd(16'h0040));
        end
        break;
      end
    end
    checks++;
    if (ack_at != LAT + 1 || m0_seen != 0) begin
      errors++;
      $display("FAIL reset_mid_latency got ack at %0d m0 acks %0d required %0d and 0", ack_at, m0_seen, LAT + 1);
    end
    checks++;
    if (m0_rdata !== 16'h0000) begin
      errors++; $display("FAIL reset_mid_rdata0 got %h required 0000", m0_rdata);
    end
  endtask

  task automatic test_drop_mid();
    int rd_cycles, acks;
    rd_cycles = 0; acks = 0;
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0050;
    for (int c = 1; c <= 2 * (LAT + 2) + 4; c++) begin
      @(negedge clk);
      if (mem_rd) begin
        rd_cycles++;
        checks++;
        if (mem_addr !== 16'h0050) begin
          errors++; $display("FAIL drop_mid_addr got %h required 0050", mem_addr);
        end
      end
      if (m0_ack) acks++;
      if (c == 1) begin m0_addr = 16'h0777; m0_req = 1'b0; end
    end
    checks++;
    if (rd_cycles != LAT || acks != 1) begin
      errors++;
      $display("FAIL drop_mid_complete got %0d strobe cycles %0d acks required %0d and 1", rd_cycles, acks, LAT);
    end
    checks++;
    if (m0_rdata !== ref_rd(16'h0050)) begin
      errors++; $display("FAIL drop_mid_data got %h required %h", m0_rdata, ref_rd(16'h0050));
    end
  endtask

  // Random traffic: the model tracks the active transaction by its grant cycle g.
  // Strobes run in cycles g..g+LAT-1, the ack lands in cycle g+LAT, and the arbiter
  // can sample requests again once the cycle index passes g+LAT.
  task automatic test_random(input int ncyc);
    bit          act, tp, twe, gid, w, in_win, is_ack, e_busy;
    int          g;
    logic [15:0] ta, tw, eaddr, ewdata, er0, er1;
    bit          e_ack  [2];
    bit          r_req  [2];
    bit          r_we   [2];
    logic [15:0] r_addr [2];
    logic [15:0] r_wd   [2];
`ifndef ARB_FIXED_PRIO_EN
    bit          last_m;
    last_m = 1'b1;
`endif
    do_reset();
    act = 1'b0; g = 0; tp = 1'b0; twe = 1'b0; ta = '0; tw = '0;
    gid = 1'b0; eaddr = '0; ewdata = '0; er0 = '0; er1 = '0;
    for (int p = 0; p < 2; p++) begin
      r_req[p] = 1'b0; r_we[p] = 1'b0; r_addr[p] = '0; r_wd[p] = '0;
    end
    for (int t = 0; t < ncyc; t++) begin
      in_win = act && t >= g && t < g + LAT;
      is_ack = act && t == g + LAT;
      e_busy = act && t >= g && t <= g + LAT;
      if (is_ack) begin
        if (twe) begin
          ref_wr[ta[11:0]] = 1'b1;
          ref_mem[ta[11:0]] = tw;
        end else if (tp) er1 = ref_rd(ta);
        else er0 = ref_rd(ta);
      end
      e_ack[0] = is_ack && !tp;
      e_ack[1] = is_ack && tp;
      checks++;
      if ({m0_ack, m1_ack, mem_rd, mem_wr, busy, gnt_id} !==
          {e_ack[0], e_ack[1], in_win && !twe, in_win && twe, e_busy, gid}) begin
        errors++;
        $display("FAIL rand_ctrl t=%0d got ack0/ack1/rd/wr/busy/gnt=%b%b%b%b%b%b required %b%b%b%b%b%b",
                 t, m0_ack, m1_ack, mem_rd, mem_wr, busy, gnt_id,
                 e_ack[0], e_ack[1], in_win && !twe, in_win && twe, e_busy, gid);
      end
      checks++;
      if ({mem_addr, mem_wdata} !== {eaddr, ewdata}) begin
        errors++;
        $display("FAIL rand_bus t=%0d got addr=%h wdata=%h required %h/%h", t, mem_addr, mem_wdata, eaddr, ewdata);
      end
      checks++;
      if ({m0_rdata, m1_rdata} !== {er0, er1}) begin
        errors++;
        $display("FAIL rand_rdata t=%0d got rd0=%h rd1=%h required %h/%h", t, m0_rdata, m1_rdata, er0, er1);
      end
      checks++;
      if (mem_rd && mem_wr) begin
        errors++; $display("FAIL rand_strobe_excl t=%0d got rd=1 wr=1 required not both", t);
      end
      for (int p = 0; p < 2; p++) begin
        if (e_ack[p]) begin
          r_req[p] = 1'($urandom_range(1, 0));
          r_we[p] = 1'($urandom_range(1, 0));
          r_addr[p] = 16'($urandom_range(15, 0));
          r_wd[p] = 16'($urandom);
        end else if (!r_req[p]) begin
          if ($urandom_range(2, 0) == 0) begin
            r_req[p] = 1'b1;
            r_we[p] = 1'($urandom_range(1, 0));
            r_addr[p] = 16'($urandom_range(15, 0));
            r_wd[p] = 16'($urandom);
          end
        end else if (act && tp == p[0] && in_win && $urandom_range(7, 0) == 0) begin
          r_we[p] = 1'($urandom_range(1, 0));
          r_addr[p] = 16'($urandom_range(15, 0));
          r_wd[p] = 16'($urandom);
          r_req[p] = 1'($urandom_range(1, 0));
        end
      end
      m0_req = r_req[0]; m0_we = r_we[0]; m0_addr = r_addr[0]; m0_wdata = r_wd[0];
      m1_req = r_req[1]; m1_we = r_we[1]; m1_addr = r_addr[1]; m1_wdata = r_wd[1];
      if ((!act || t > g + LAT) && (r_req[0] || r_req[1])) begin
`ifdef ARB_FIXED_PRIO_EN
        w = !r_req[0];
`else
        w = (r_req[0] && r_req[1]) ? !last_m : r_req[1];
        last_m = w;
`endif
        act = 1'b1; g = t + 1; tp = w;
        twe = r_we[w]; ta = r_addr[w]; tw = r_wd[w];
        gid = w; eaddr = ta; ewdata = tw;
      end
      @(negedge clk);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (LAT + 3) @(negedge clk);
  endtask

  initial begin
    rst_b = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < 4096; i++) begin
      ref_wr[i] = 1'b0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_m0_read();
    test_m1_write();
    test_round_robin();
    test_reset_mid();
    test_drop_mid();
    test_random(2000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
